fft16_frame_ctrl: RTL and testbench

FFT16_FRAME_CTRL -- requirements
Module: fft16_frame_ctrl

---
 rtl/fft16_frame_ctrl.sv | 94 +++++++++
 tb/tb_fft16_frame_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fft16_frame_ctrl.sv
// fft16_frame_ctrl: gathers a 16-sample frame into a staging bank, kicks a
// 16-point FFT, waits for completion with a watchdog and streams out the bins.
module fft16_frame_ctrl #(
  parameter int N       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  input  logic [N-1:0] i_s_re,
  input  logic [N-1:0] i_s_im,
  output logic         o_load_en,
  output logic [3:0]   o_load_idx,
  output logic [N-1:0] o_load_re,
  output logic [N-1:0] o_load_im,
  output logic         o_bank_we,
  output logic         o_fft_start,
  input  logic         i_fft_done,
  output logic [3:0]   o_rd_idx,
  input  logic [N-1:0] i_rd_re,
  input  logic [N-1:0] i_rd_im,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic [N-1:0] o_m_re,
  output logic [N-1:0] o_m_im,
  output logic         o_m_last,
  output logic         o_frame_done,
  output logic         o_err,
  output logic         o_busy
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, START, WAIT, UNLOAD} state_t;
  state_t state, state_nxt;
  logic [3:0]    cnt;
  logic [WW-1:0] wcnt;
  logic          xfer, beat, unload, tmo;
  assign unload = state == UNLOAD;
  assign xfer   = i_s_valid && o_s_ready;
  assign beat   = unload && i_m_ready;
  assign tmo    = state == WAIT && !i_fft_done && wcnt == WW'(TIMEOUT - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = LOAD;
      LOAD:    if (xfer && cnt == 4'd15) state_nxt = COMMIT;
      COMMIT:  state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    state_nxt = i_fft_done ? UNLOAD : tmo ? IDLE : WAIT;
      UNLOAD:  if (beat && cnt == 4'd15) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // ready is forced low while reset is held so every output reads 0 in reset
  always_comb begin
    o_s_ready = i_rst_n && (state == IDLE || state == LOAD);
    o_busy    = state != IDLE;
    o_m_valid = unload;
    o_rd_idx  = unload ? cnt : 4'd0;
    o_m_re    = unload ? i_rd_re : '0;
    o_m_im    = unload ? i_rd_im : '0;
    o_m_last  = unload && cnt == 4'd15;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt          <= '0;
      wcnt         <= '0;
      o_load_en    <= 1'b0;
      o_load_idx   <= '0;
      o_load_re    <= '0;
      o_load_im    <= '0;
      o_bank_we    <= 1'b0;
      o_fft_start  <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      if (xfer || beat) cnt <= cnt + 4'd1;
      else if (state == WAIT && i_fft_done) cnt <= '0;
      wcnt         <= state == WAIT ? wcnt + 1'b1 : '0;
      o_load_en    <= xfer;
      if (xfer) begin
        o_load_idx <= cnt;
        o_load_re  <= i_s_re;
        o_load_im  <= i_s_im;
      end
      o_bank_we    <= state == COMMIT;
      o_fft_start  <= state == START;
      o_frame_done <= beat && cnt == 4'd15;
      o_err        <= o_err | tmo;
    end
endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// tb_fft16_frame_ctrl: directed frames with a queue scoreboard; a negedge
// monitor checks staging writes, output beats, stalls and frame_done.
module tb_fft16_frame_ctrl;
  localparam int N = 16;
  logic         clk = 0, rst_n = 0;
  logic         s_valid = 0, s_ready;
  logic [N-1:0] s_re = 0, s_im = 0;
  logic         load_en;
  logic [3:0]   load_idx;
  logic [N-1:0] load_re, load_im;
  logic         bank_we, fft_start, fft_done = 0;
  logic [3:0]   rd_idx;
  logic [N-1:0] rd_re, rd_im;
  logic         m_valid, m_ready = 0;
  logic [N-1:0] m_re, m_im;
  logic         m_last, frame_done, err, busy;

  fft16_frame_ctrl #(.N(N), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_s_re(s_re), .i_s_im(s_im), .o_load_en(load_en), .o_load_idx(load_idx),
    .o_load_re(load_re), .o_load_im(load_im), .o_bank_we(bank_we),
    .o_fft_start(fft_start), .i_fft_done(fft_done), .o_rd_idx(rd_idx),
    .i_rd_re(rd_re), .i_rd_im(rd_im), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_re(m_re), .o_m_im(m_im), .o_m_last(m_last), .o_frame_done(frame_done),
    .o_err(err), .o_busy(busy));

  always #5 clk = ~clk;
  assign rd_re = 16'(rd_idx) * 16'd4;
  assign rd_im = 16'(rd_idx) + 16'd100;

  int checks = 0, failures = 0;
  int beats = 0, vcyc = 0, fd_seen = 0;
  logic [35:0] load_q[$];
  logic [32:0] beat_q[$];
  logic        expect_fd = 0, stall = 0;
  logic [3:0]  s_idx = 0;
  logic [N-1:0] s_mre = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      expect_fd = 0;
      stall = 0;
    end else begin
      if (expect_fd || frame_done) begin
        check("frame_done", frame_done, expect_fd);
        check("idle_after_frame", busy, 0);
        if (frame_done) fd_seen++;
      end
      expect_fd = 0;
      if (stall) begin
        check("hold_rd_idx", rd_idx, s_idx);
        check("hold_m_re", m_re, s_mre);
      end
      stall = m_valid && !m_ready;
      s_idx = rd_idx;
      s_mre = m_re;
      if (m_valid) vcyc++;
      if (load_en) begin
        if (load_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL load_unexpected: idx %0d with empty queue", load_idx);
        end else check("load", {load_idx, load_re, load_im}, load_q.pop_front());
      end
      if (m_valid && m_ready) begin
        if (beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected: rd_idx %0d with empty queue", rd_idx);
        end else check("beat", {m_re, m_im, m_last}, beat_q.pop_front());
        beats++;
        expect_fd = m_last;
      end
    end
  end

  task automatic send_frame(input int n, input int dk);
    for (int k = 0; k < n; k++) begin
      s_valid = 1; s_re = 16'(k); s_im = 16'(-k); fft_done = (k == dk);
      load_q.push_back({4'(k), 16'(k), 16'(-k)});
      check("s_ready_high", s_ready, 1);
      tick;
    end
    s_valid = 0; fft_done = 0;
    if (n == 16) check("s_ready_low", s_ready, 0);
  endtask

  task automatic start_seq(input bit ps);
    check("bank_we_early", bank_we, 0);
    tick;
    check("bank_we", bank_we, 1);
    check("fft_start_early", fft_start, 0);
    fft_done = ps;
    tick;
    fft_done = 0;
    check("bank_we_once", bank_we, 0);
    check("fft_start", fft_start, 1);
    check("busy_wait", busy, 1);
    tick;
    check("fft_start_once", fft_start, 0);
  endtask

  task automatic wait_done(input int n);
    for (int b = 0; b < 16; b++) beat_q.push_back({16'(4 * b), 16'(100 + b), b == 15});
    repeat (n) tick;
    check("no_valid_in_wait", m_valid, 0);
    fft_done = 1;
    tick;
    fft_done = 0;
  endtask

  task automatic unload(input bit tg);
    int b0, v0, f0, cyc;
    b0 = beats; v0 = vcyc; f0 = fd_seen; cyc = 0;
    m_ready = !tg;
    while (fd_seen == f0 && cyc < 100) begin
      tick;
      cyc++;
      if (tg) m_ready = !m_ready;
    end
    m_ready = 0;
    if (fd_seen == f0) begin
      checks++; failures++;
      $display("FAIL unload_timeout: no frame_done within %0d cycles", cyc);
    end
    check("beat_count", beats - b0, 16);
    check("valid_cycles", vcyc - v0, tg ? 32 : 16);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench stalled");
    $fatal(1, "timeout");
  end

  initial begin
    tick; tick;
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_load_en", load_en, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    #1;
    check("post_rst_s_ready", s_ready, 1);
    // basic frame, done after 5 wait cycles, ready held high
    send_frame(16, -1);
    start_seq(0);
    wait_done(4);
    unload(0);
    // backpressure: ready toggles every cycle
    send_frame(16, -1);
    start_seq(0);
    wait_done(0);
    unload(1);
    // watchdog expiry with TIMEOUT=8
    send_frame(16, -1);
    start_seq(0);
    repeat (6) tick;
    check("err_before_timeout", err, 0);
    check("busy_before_timeout", busy, 1);
    tick;
    check("err_timeout", err, 1);
    check("idle_after_timeout", busy, 0);
    check("ready_after_timeout", s_ready, 1);
    // done pulses in LOAD and START are ignored; err stays set
    send_frame(16, 5);
    start_seq(1);
    tick; tick;
    check("still_wait_busy", busy, 1);
    check("still_wait_novalid", m_valid, 0);
    wait_done(0);
    unload(0);
    check("err_sticky", err, 1);
    // reset mid-load
    send_frame(7, -1);
    #2 rst_n = 0;
    #1;
    load_q.delete();
    check("midrst_load_en", load_en, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_load_idx", load_idx, 0);
    tick;
    rst_n = 1;
    #1;
    send_frame(16, -1);
    start_seq(0);
    wait_done(1);
    unload(0);
    check("final_err", err, 0);
    check("load_q_drained", load_q.size(), 0);
    check("beat_q_drained", beat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
